// File: rtl/alu_multicycle.sv
`default_nettype none
// ============================================================================
// Module   : alu_multicycle
// Brief    : Registered EX-stage ALU with valid/ready input handshake,
//            iterative multiply/divide into HI/LO and MFHI/MFLO readback.
// Revision : 1.0
// ============================================================================
module alu_multicycle #(
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         op1,
    input  logic [WIDTH-1:0]         op2,
    input  logic [$clog2(WIDTH)-1:0] shamt,
    input  logic [5:0]               selection,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         result,
    output logic                     zero,
    output logic                     div_by_zero,
    output logic                     busy
);

    localparam int SHW  = $clog2(WIDTH);
    localparam int CNTW = SHW + 1;

    localparam logic [5:0] c_sel_sll   = 6'b000000;
    localparam logic [5:0] c_sel_srl   = 6'b000010;
    localparam logic [5:0] c_sel_sra   = 6'b000011;
    localparam logic [5:0] c_sel_mfhi  = 6'b010000;
    localparam logic [5:0] c_sel_mflo  = 6'b010010;
    localparam logic [5:0] c_sel_mult  = 6'b011000;
    localparam logic [5:0] c_sel_multu = 6'b011001;
    localparam logic [5:0] c_sel_div   = 6'b011010;
    localparam logic [5:0] c_sel_divu  = 6'b011011;
    localparam logic [5:0] c_sel_sub   = 6'b100010;
    localparam logic [5:0] c_sel_and   = 6'b100100;
    localparam logic [5:0] c_sel_or    = 6'b100101;
    localparam logic [5:0] c_sel_xor   = 6'b100110;
    localparam logic [5:0] c_sel_nor   = 6'b100111;
    localparam logic [5:0] c_sel_slt   = 6'b101010;
    localparam logic [5:0] c_sel_sltu  = 6'b101011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [CNTW-1:0]      r_cnt;
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_div, r_a, r_hi, r_lo, r_result;
    logic                 r_neg_q, r_neg_r, r_is_div, r_dbz;
    logic                 r_zero, r_dbz_out, r_out_valid;

    logic                 w_accept, w_is_mul, w_is_div, w_signed;
    logic [WIDTH-1:0]     w_alu, w_mag1, w_mag2, w_fin_hi, w_fin_lo;
    logic [WIDTH:0]       w_madd, w_shift, w_trial;
    logic [2*WIDTH-1:0]   w_mul_next, w_div_next, w_prod;

    function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] v, input logic s);
        return (s && v[WIDTH-1]) ? -v : v;
    endfunction

    assign in_ready    = (r_state == S_IDLE);
    assign busy        = !in_ready;
    assign out_valid   = r_out_valid;
    assign result      = r_result;
    assign zero        = r_zero;
    assign div_by_zero = r_dbz_out;

    assign w_accept = in_valid && in_ready;
    assign w_is_mul = (selection == c_sel_mult) || (selection == c_sel_multu);
    assign w_is_div = (selection == c_sel_div)  || (selection == c_sel_divu);
    assign w_signed = !selection[0];
    assign w_mag1   = f_mag(op1, w_signed);
    assign w_mag2   = f_mag(op2, w_signed);

    // Shift-add step: multiplier in low half, partial product grows in the high half.
    assign w_madd     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_div} : '0);
    assign w_mul_next = {w_madd, r_acc[WIDTH-1:1]};

    // Restoring step: remainder in high half, quotient bits shift into the low half.
    assign w_shift    = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_trial    = w_shift - {1'b0, r_div};
    assign w_div_next = w_trial[WIDTH] ? {w_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                       : {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

    assign w_prod = r_neg_q ? -r_acc : r_acc;

    always_comb begin
        w_fin_hi = w_prod[2*WIDTH-1:WIDTH];
        w_fin_lo = w_prod[WIDTH-1:0];
        if (r_dbz) begin
            w_fin_hi = r_a;
            w_fin_lo = '1;
        end else if (r_is_div) begin
            w_fin_hi = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
            w_fin_lo = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
        end
    end

    always_comb begin
        case (selection)
            c_sel_sub:  w_alu = op1 - op2;
            c_sel_and:  w_alu = op1 & op2;
            c_sel_or:   w_alu = op1 | op2;
            c_sel_xor:  w_alu = op1 ^ op2;
            c_sel_nor:  w_alu = ~(op1 | op2);
            c_sel_slt:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
            c_sel_sltu: w_alu = {{(WIDTH-1){1'b0}}, (op1 < op2)};
            c_sel_sll:  w_alu = op2 << shamt;
            c_sel_srl:  w_alu = op2 >> shamt;
            c_sel_sra:  w_alu = $unsigned($signed(op2) >>> shamt);
            c_sel_mfhi: w_alu = r_hi;
            c_sel_mflo: w_alu = r_lo;
            default:    w_alu = op1 + op2;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_is_mul)      w_state_nxt = S_MUL;
                else if (w_accept && w_is_div) w_state_nxt = S_DIV;
            end
            S_MUL:   if (r_cnt == CNTW'(1)) w_state_nxt = S_FIN;
            S_DIV:   if (r_dbz || (r_cnt == CNTW'(1))) w_state_nxt = S_FIN;
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_acc       <= '0;
            r_div       <= '0;
            r_a         <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_is_div    <= 1'b0;
            r_dbz       <= 1'b0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_result    <= '0;
            r_zero      <= 1'b1;
            r_dbz_out   <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept && (w_is_mul || w_is_div)) begin
                        r_cnt    <= CNTW'(WIDTH);
                        r_a      <= op1;
                        r_is_div <= w_is_div;
                        r_dbz    <= w_is_div && (op2 == '0);
                        r_neg_q  <= w_signed && (op1[WIDTH-1] ^ op2[WIDTH-1]);
                        r_neg_r  <= w_signed && op1[WIDTH-1];
                        r_acc    <= {{WIDTH{1'b0}}, (w_is_div ? w_mag1 : w_mag2)};
                        r_div    <= w_is_div ? w_mag2 : w_mag1;
                    end else if (w_accept) begin
                        r_result    <= w_alu;
                        r_zero      <= (w_alu == '0);
                        r_dbz_out   <= 1'b0;
                        r_out_valid <= 1'b1;
                    end
                end
                S_MUL: begin
                    r_acc <= w_mul_next;
                    r_cnt <= r_cnt - CNTW'(1);
                end
                S_DIV: begin
                    if (!r_dbz) begin
                        r_acc <= w_div_next;
                        r_cnt <= r_cnt - CNTW'(1);
                    end
                end
                S_FIN: begin
                    r_hi        <= w_fin_hi;
                    r_lo        <= w_fin_lo;
                    r_result    <= w_fin_lo;
                    r_zero      <= (w_fin_lo == '0);
                    r_dbz_out   <= r_dbz;
                    r_out_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_multicycle.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_multicycle
// Brief    : Scoreboard bench for 32-bit and 8-bit alu_multicycle instances.
// Revision : 1.0
// ============================================================================
module tb_alu_multicycle;

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic        dbz;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    logic        iv32 = 1'b0, iv8 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [4:0]  sh32 = '0;
    logic [2:0]  sh8 = '0;
    logic [5:0]  sel32 = '0, sel8 = '0;
    logic        rdy32, rdy8, ov32, ov8, z32, z8, dz32, dz8, bsy32, bsy8;
    logic [31:0] res32;
    logic [7:0]  res8;

    exp_t        q32[$], q8[$];
    exp_t        last32, last8;
    logic [31:0] mhi[2], mlo[2];
    int          ready_at[2];

    alu_multicycle #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(rdy32), .op1(a32), .op2(b32),
        .shamt(sh32), .selection(sel32), .out_valid(ov32), .result(res32), .zero(z32),
        .div_by_zero(dz32), .busy(bsy32)
    );

    alu_multicycle #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(rdy8), .op1(a8), .op2(b8),
        .shamt(sh8), .selection(sel8), .out_valid(ov8), .result(res8), .zero(z8),
        .div_by_zero(dz8), .busy(bsy8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s at cycle %0d: got 0x%08h expected 0x%08h", nm, cyc, act, expv);
        end
    endtask

    // Reference behaviour computed with plain 64-bit arithmetic on w-bit operands.
    function automatic exp_t model(input int w, input logic [5:0] sel, input logic [31:0] a,
                                   input logic [31:0] b, input int sh,
                                   inout logic [31:0] hi, inout logic [31:0] lo,
                                   output int lat);
        logic [63:0] mask, ua, ub, t, p;
        longint      sa, sb, sq, sr;
        exp_t        e;
        mask = (64'd1 << w) - 64'd1;
        ua = {32'd0, a} & mask;
        ub = {32'd0, b} & mask;
        t  = ua << (64 - w);
        sa = $signed(t) >>> (64 - w);
        t  = ub << (64 - w);
        sb = $signed(t) >>> (64 - w);
        lat   = 1;
        e.dbz = 1'b0;
        e.due = 0;
        case (sel)
            6'b100010: p = ua - ub;
            6'b100100: p = ua & ub;
            6'b100101: p = ua | ub;
            6'b100110: p = ua ^ ub;
            6'b100111: p = ~(ua | ub);
            6'b101010: p = (sa < sb) ? 64'd1 : 64'd0;
            6'b101011: p = (ua < ub) ? 64'd1 : 64'd0;
            6'b000000: p = ub << sh;
            6'b000010: p = ub >> sh;
            6'b000011: p = $unsigned(sb >>> sh);
            6'b010000: p = {32'd0, hi};
            6'b010010: p = {32'd0, lo};
            6'b011000, 6'b011001: begin
                lat = w + 2;
                p   = sel[0] ? ua * ub : $unsigned(sa * sb);
                hi  = 32'((p >> w) & mask);
                lo  = 32'(p & mask);
                p   = {32'd0, lo};
            end
            6'b011010, 6'b011011: begin
                if (ub == 64'd0) begin
                    lat   = 3;
                    lo    = 32'(mask);
                    hi    = 32'(ua);
                    e.dbz = 1'b1;
                end else begin
                    lat = w + 2;
                    if (sel[0]) begin
                        lo = 32'((ua / ub) & mask);
                        hi = 32'((ua % ub) & mask);
                    end else begin
                        sq = sa / sb;
                        sr = sa % sb;
                        lo = 32'($unsigned(sq) & mask);
                        hi = 32'($unsigned(sr) & mask);
                    end
                end
                p = {32'd0, lo};
            end
            default:   p = ua + ub;
        endcase
        e.res  = 32'(p & mask);
        e.zero = (e.res == 32'd0);
        return e;
    endfunction

    // One cycle of stimulus; the op is scored only if the model says the DUT is idle.
    task automatic drive(input int d, input logic [5:0] sel, input logic [31:0] a,
                         input logic [31:0] b, input int sh, output bit acc);
        exp_t e;
        int   lat, w;
        @(negedge clk);
        #1;
        w = (d == 0) ? 32 : 8;
        if (d == 0) begin
            iv32 = 1'b1; a32 = a; b32 = b; sh32 = 5'(sh); sel32 = sel; iv8 = 1'b0;
        end else begin
            iv8 = 1'b1; a8 = a[7:0]; b8 = b[7:0]; sh8 = 3'(sh); sel8 = sel; iv32 = 1'b0;
        end
        acc = (cyc >= ready_at[d]);
        if (acc) begin
            e = model(w, sel, a, b, sh % w, mhi[d], mlo[d], lat);
            e.due = cyc + lat;
            if (lat > 1) ready_at[d] = cyc + lat;
            if (d == 0) q32.push_back(e);
            else        q8.push_back(e);
        end
    endtask

    task automatic issue(input int d, input logic [5:0] sel, input logic [31:0] a,
                         input logic [31:0] b, input int sh);
        bit acc;
        acc = 1'b0;
        for (int i = 0; i < 100 && !acc; i++) drive(d, sel, a, b, sh, acc);
        if (!acc) chk("issue_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
            iv32 = 1'b0;
            iv8  = 1'b0;
        end
    endtask

    task automatic model_reset();
        q32.delete();
        q8.delete();
        for (int i = 0; i < 2; i++) begin
            mhi[i] = '0;
            mlo[i] = '0;
            ready_at[i] = cyc;
        end
        last32 = '{res: 32'd0, zero: 1'b1, dbz: 1'b0, due: 0};
        last8  = '{res: 32'd0, zero: 1'b1, dbz: 1'b0, due: 0};
    endtask

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            4:       return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [31:0] narrow(input logic [31:0] v, input int d);
        if (d == 0) return v;
        if (v == 32'h8000_0000) return 32'h80;
        return v;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        bit   ev;
        ev = (q32.size() > 0) && (q32[0].due == cyc);
        chk("w32_out_valid", 32'(ov32), 32'(ev));
        chk("w32_in_ready", 32'(rdy32), 32'(cyc >= ready_at[0]));
        chk("w32_busy", 32'(bsy32), 32'(cyc < ready_at[0]));
        if (ev) begin
            e = q32.pop_front();
            last32 = e;
        end
        if (ev || !ov32) begin
            chk("w32_result", res32, last32.res);
            chk("w32_zero", 32'(z32), 32'(last32.zero));
            chk("w32_div_by_zero", 32'(dz32), 32'(last32.dbz));
        end
        ev = (q8.size() > 0) && (q8[0].due == cyc);
        chk("w8_out_valid", 32'(ov8), 32'(ev));
        chk("w8_in_ready", 32'(rdy8), 32'(cyc >= ready_at[1]));
        chk("w8_busy", 32'(bsy8), 32'(cyc < ready_at[1]));
        if (ev) begin
            e = q8.pop_front();
            last8 = e;
        end
        if (ev || !ov8) begin
            chk("w8_result", 32'(res8), last8.res);
            chk("w8_zero", 32'(z8), 32'(last8.zero));
            chk("w8_div_by_zero", 32'(dz8), 32'(last8.dbz));
        end
    end

    localparam logic [5:0] c_codes [18] = '{
        6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110, 6'b100111,
        6'b101010, 6'b101011, 6'b000000, 6'b000010, 6'b000011, 6'b010000,
        6'b010010, 6'b011000, 6'b011001, 6'b011010, 6'b011011, 6'b111111
    };

    initial begin
        logic [5:0] s;
        bit         acc;
        int         n;
        model_reset();
        #2 rst = 1'b1;
        idle(2);
        #1;
        chk("reset_result32", res32, 32'd0);
        chk("reset_zero32", 32'(z32), 32'd1);
        chk("reset_ready32", 32'(rdy32), 32'd1);
        chk("reset_result8", 32'(res8), 32'd0);
        rst = 1'b0;
        model_reset();

        issue(0, 6'b100000, 32'd5, 32'd7, 0);
        issue(0, 6'b100010, 32'd7, 32'd7, 0);
        issue(0, 6'b101010, 32'hFFFF_FFFF, 32'd1, 0);
        issue(0, 6'b101011, 32'hFFFF_FFFF, 32'd1, 0);
        issue(0, 6'b000011, 32'd0, 32'h8000_0000, 4);
        issue(0, 6'b011000, -32'd3, 32'd7, 0);
        issue(0, 6'b010000, 32'd0, 32'd0, 0);
        issue(0, 6'b010010, 32'd0, 32'd0, 0);
        issue(0, 6'b011010, -32'd7, 32'd2, 0);
        issue(0, 6'b011011, 32'd9, 32'd0, 0);
        issue(0, 6'b010000, 32'd0, 32'd0, 0);
        issue(0, 6'b011010, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        issue(0, 6'b010000, 32'd0, 32'd0, 0);

        // Abort a multu mid-flight; HI/LO must come back cleared.
        issue(0, 6'b011001, 32'h1234_5678, 32'h9ABC_DEF0, 0);
        idle(9);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_in_ready", 32'(rdy32), 32'd1);
        chk("midrst_out_valid", 32'(ov32), 32'd0);
        model_reset();
        idle(2);
        rst = 1'b0;
        issue(0, 6'b010000, 32'd0, 32'd0, 0);
        issue(0, 6'b010010, 32'd0, 32'd0, 0);

        issue(1, 6'b011001, 32'hFF, 32'hFF, 0);
        issue(1, 6'b100000, 32'd3, 32'd4, 0);
        issue(1, 6'b010000, 32'd0, 32'd0, 0);
        issue(1, 6'b011010, 32'h80, 32'hFF, 0);
        issue(1, 6'b010000, 32'd0, 32'd0, 0);

        for (int d = 0; d < 2; d++) begin
            n = (d == 0) ? 300 : 200;
            for (int i = 0; i < n; i++) begin
                s = c_codes[$urandom_range(0, 17)];
                if (s == 6'b111111) s = 6'($urandom);
                if ($urandom_range(0, 9) == 0) idle(1);
                drive(d, s, narrow(rnd_op(), d), narrow(rnd_op(), d), $urandom_range(0, 31), acc);
            end
        end

        idle(1);
        for (int i = 0; i < 100 && (q32.size() > 0 || q8.size() > 0); i++) idle(1);
        if (q32.size() > 0 || q8.size() > 0) chk("drain_timeout", 32'(q32.size() + q8.size()), 32'd0);
        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
